exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between the ID/EXE pipeline register and the EXE/MEM pipeline register.
- Selects forwarded operands and computes single-cycle ALU results.
- Resolves branches and produces the branch target and the IF/ID flush request.
- Runs an iterative 32-cycle multiply/divide unit. While it is busy, the unit freezes the upstream pipeline through freez_req.

Parameters:
- len, 32, width of pc_in and branch_addr

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_in  in  len  pc of the EXE instruction (already pc+4)
- exe_cmd  in  4  operation code from ID/EXE
- branch_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- alu_inp1  in  32  operand 1 from ID/EXE
- alu_inp2  in  32  operand 2 or sign-extended immediate from ID/EXE
- reg2  in  32  rt value (store data / BNE comparand) from ID/EXE
- fwd_sel1, fwd_sel2, fwd_sel_st  in  2 each  00 ID/EXE value, 01 mem_fwd, 10 wb_fwd, 11 reserved (acts as 00)
- mem_fwd  in  32  ALU result currently in the MEM stage
- wb_fwd  in  32  write-back value
- alu_result  out  32  result to EXE/MEM
- st_val  out  32  forwarded store data to EXE/MEM
- branch_taken  out  1  branch resolved taken; flushes IF/ID and ID/EXE
- branch_addr  out  len  branch/jump target
- freez_req  out  1  freeze PC, IF/ID and ID/EXE; insert bubble into EXE/MEM

Behaviour:
- Operand selection: val1 = mux(fwd_sel1: alu_inp1, mem_fwd, wb_fwd). val2 is muxed the same way from alu_inp2 using fwd_sel2. st_val is muxed the same way from reg2 using fwd_sel_st. All combinational.
- Single-cycle exe_cmd set (combinational, 0 latency), all results modulo 2^32:
  - 0000 ADD; 0010 SUB (val1-val2); 0100 AND; 0101 OR; 0110 NOR; 0111 XOR.
  - 1000 SLA and 1001 SLL: val1 << val2[4:0].
  - 1010 SRA: arithmetic right shift by val2[4:0].
  - 1011 SRL: logical right shift by val2[4:0].
  - Unlisted codes give alu_result = 0.
- Branch, combinational:
  - branch_addr = pc_in + {val2[len-3:0],2'b00}.
  - branch_taken = (BEZ & val1==0) | (BNE & val1!=st_val) | JMP.
  - branch_taken is forced to 0 while freez_req=1.
- Multi-cycle exe_cmd set: 1100 MUL (unsigned shift-add, low 32 bits of product); 1101 DIV (unsigned restoring, quotient).
- Muldiv FSM states: IDLE, BUSY, DONE.
  - IDLE: if exe_cmd is MUL/DIV, freez_req=1 combinationally in this cycle. At the next edge, latch val1/val2 and the op, clear the product/remainder, set count=0, go to BUSY.
  - BUSY: one iteration per cycle, freez_req=1. count increments each cycle; at count==31, go to DONE at the next edge.
  - DONE: freez_req=0 and alu_result = latched result. The pipeline advances at the next edge and the FSM returns to IDLE on that edge.
  - A back-to-back MUL/DIV therefore starts in the following IDLE cycle with no gap loss.
- Muldiv latency: 1 IDLE + 32 BUSY = 33 frozen cycles; the result appears in cycle 34 (DONE).
- Operands are latched at start. Forwarding changes during BUSY have no effect.
- DIV with divisor 0 produces quotient 32'hFFFFFFFF and raises no fault.
- During IDLE-start and BUSY, alu_result = 0.
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE, count=0, result and operand registers = 0, freez_req=0.
  - Reset mid-operation abandons the op; no result is produced.
- Reset values of outputs with reset held and all inputs 0:
  - alu_result=0, st_val=0, branch_taken=0, branch_addr=0, freez_req=0.
  - Combinational outputs otherwise follow their inputs.
- A bubble (exe_cmd 0000, branch_type 00) produces an ADD result. This is harmless because the write-back enable is carried separately.

Test Plan:
1. Forwarding: alu_inp1=5, mem_fwd=7, wb_fwd=9, alu_inp2=3, exe_cmd ADD. Sweep fwd_sel1 over 00/01/10/11 -> alu_result = 8, 10, 12, 8.
2. Shifts and SUB:
   - val1=32'h8000_0000, val2=4: SRA -> F800_0000; SRL -> 0800_0000.
   - SUB with val1=1, val2=2 -> FFFF_FFFF.
3. Branches: pc_in=100, alu_inp2=3.
   - BEZ with val1=0 -> branch_taken=1, branch_addr=112.
   - BNE with val1=st_val=4 -> branch_taken=0.
   - JMP -> branch_taken=1.
4. MUL 12345 x 6789:
   - freez_req high for exactly 33 cycles.
   - Cycle 34: alu_result = 83810205, freez_req=0.
   - FSM is in IDLE the following cycle.
5. DIV cases:
   - 100/7 -> 14.
   - 5/0 -> FFFF_FFFF.
   - Back-to-back DIV then MUL (2x3): second op starts immediately after the first op's DONE; results 14 then 6.
6. Asynchronous reset mid-MUL at count 10:
   - freez_req drops immediately with no clock edge.
   - After release, a fresh MUL 3x4 completes with result 12.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolve, iterative MUL/DIV.
// ALU/branch are 0-latency; MUL/DIV hold freez_req for 33 cycles, result shown in cycle 34.
module exe_stage #(
  parameter int len = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [len-1:0] pc_in,
  input  logic [3:0]     exe_cmd,
  input  logic [1:0]     branch_type,
  input  logic [31:0]    alu_inp1,
  input  logic [31:0]    alu_inp2,
  input  logic [31:0]    reg2,
  input  logic [1:0]     fwd_sel1,
  input  logic [1:0]     fwd_sel2,
  input  logic [1:0]     fwd_sel_st,
  input  logic [31:0]    mem_fwd,
  input  logic [31:0]    wb_fwd,
  output logic [31:0]    alu_result,
  output logic [31:0]    st_val,
  output logic           branch_taken,
  output logic [len-1:0] branch_addr,
  output logic           freez_req
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t   state, state_nxt;
  logic [4:0]  count;
  logic        op_div;
  logic [31:0] opa;   // multiplicand, or dividend shifting into quotient
  logic [31:0] opb;   // multiplier, or divisor
  logic [31:0] acc;   // product, or partial remainder

  logic [31:0] val1, val2;
  logic [31:0] alu_comb;
  logic        md_cmd;
  logic        br_raw;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic [31:0] md_res;

  always_comb begin
    case (fwd_sel1)
      2'b01:   val1 = mem_fwd;
      2'b10:   val1 = wb_fwd;
      default: val1 = alu_inp1;
    endcase
    case (fwd_sel2)
      2'b01:   val2 = mem_fwd;
      2'b10:   val2 = wb_fwd;
      default: val2 = alu_inp2;
    endcase
    case (fwd_sel_st)
      2'b01:   st_val = mem_fwd;
      2'b10:   st_val = wb_fwd;
      default: st_val = reg2;
    endcase
  end

  always_comb begin
    alu_comb = 32'd0;
    case (exe_cmd)
      4'b0000: alu_comb = val1 + val2;
      4'b0010: alu_comb = val1 - val2;
      4'b0100: alu_comb = val1 & val2;
      4'b0101: alu_comb = val1 | val2;
      4'b0110: alu_comb = ~(val1 | val2);
      4'b0111: alu_comb = val1 ^ val2;
      4'b1000,
      4'b1001: alu_comb = val1 << val2[4:0];
      4'b1010: alu_comb = $unsigned($signed(val1) >>> val2[4:0]);
      4'b1011: alu_comb = val1 >> val2[4:0];
      default: alu_comb = 32'd0;
    endcase
  end

  assign md_cmd = (exe_cmd[3:1] == 3'b110);
  assign md_res = op_div ? opa : acc;

  // Reset gates the freeze so a held MUL/DIV command cannot re-freeze during reset.
  assign freez_req = reset & (((state == IDLE) & md_cmd) | (state == BUSY));

  always_comb begin
    if (state == DONE)
      alu_result = md_res;
    else if (md_cmd || state == BUSY)
      alu_result = 32'd0;
    else
      alu_result = alu_comb;
  end

  assign branch_addr = pc_in + {val2[len-3:0], 2'b00};
  assign br_raw = ((branch_type == 2'b01) & (val1 == 32'd0)) |
                  ((branch_type == 2'b10) & (val1 != st_val)) |
                  (branch_type == 2'b11);
  assign branch_taken = br_raw & ~freez_req;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_cmd) state_nxt = BUSY;
      BUSY:    if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring divide step: shift one dividend bit into the remainder, subtract if it fits.
  assign rem_sh  = {acc, opa[31]};
  assign rem_ge  = (rem_sh >= {1'b0, opb});
  assign rem_sub = rem_sh[31:0] - opb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      op_div <= 1'b0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      acc    <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (md_cmd) begin
            op_div <= exe_cmd[0];
            opa    <= val1;
            opb    <= val2;
            acc    <= 32'd0;
            count  <= 5'd0;
          end
        end
        BUSY: begin
          count <= count + 5'd1;
          if (op_div) begin
            opa <= {opa[30:0], rem_ge};
            acc <= rem_ge ? rem_sub : rem_sh[31:0];
          end else begin
            acc <= acc + (opb[0] ? opa : 32'd0);
            opa <= {opa[30:0], 1'b0};
            opb <= {1'b0, opb[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for combinational paths, sequences for MUL/DIV and reset.
module tb_exe_stage;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic [3:0]  exe_cmd;
  logic [1:0]  branch_type;
  logic [31:0] alu_inp1, alu_inp2, reg2;
  logic [1:0]  fwd_sel1, fwd_sel2, fwd_sel_st;
  logic [31:0] mem_fwd, wb_fwd;
  logic [31:0] alu_result, st_val, branch_addr;
  logic        branch_taken, freez_req;

  int checks = 0;
  int errors = 0;

  exe_stage #(.len(32)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .exe_cmd(exe_cmd),
    .branch_type(branch_type), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .reg2(reg2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_sel_st(fwd_sel_st), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .alu_result(alu_result), .st_val(st_val), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .freez_req(freez_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h2, C_AND = 4'h4, C_OR = 4'h5;
  localparam logic [3:0] C_NOR = 4'h6, C_XOR = 4'h7, C_SLA = 4'h8, C_SLL = 4'h9;
  localparam logic [3:0] C_SRA = 4'hA, C_SRL = 4'hB, C_MUL = 4'hC, C_DIV = 4'hD;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  bt, s1, s2, sst;
    logic [31:0] i1, i2, r2;
    logic [31:0] res;
    logic        tk;
    logic [31:0] addr, st;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [0:NV-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Starts a MUL/DIV just after a rising edge; returns just after the edge that ends DONE.
  task automatic run_md(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int frz;
    frz = 0;
    exe_cmd = cmd; alu_inp1 = a; alu_inp2 = b; branch_type = 2'd0;
    fwd_sel1 = 2'd0; fwd_sel2 = 2'd0; fwd_sel_st = 2'd0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!freez_req) break;
      frz++;
      if (frz == 5) check({name, "_busy_res"}, alu_result, 32'd0);
      @(posedge clock); #1;
      if (frz == 2) begin
        alu_inp1 = ~a; alu_inp2 = ~b; mem_fwd = 32'hDEAD_BEEF;
      end
    end
    check({name, "_frozen_cycles"}, 32'(frz), 32'd33);
    check({name, "_result"}, alu_result, exp);
    check({name, "_done_freez"}, {31'd0, freez_req}, 32'd0);
    @(posedge clock); #1;
    mem_fwd = 32'd7;
  endtask

  initial begin
    //           cmd    bt    s1    s2    sst   i1            i2            r2   res           tk    addr          st
    vecs[0]  = '{C_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd8,        1'b0, 32'd112,      32'd0};
    vecs[1]  = '{C_ADD, 2'd0, 2'd1, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd10,       1'b0, 32'd112,      32'd0};
    vecs[2]  = '{C_ADD, 2'd0, 2'd2, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd12,       1'b0, 32'd112,      32'd0};
    vecs[3]  = '{C_ADD, 2'd0, 2'd3, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd8,        1'b0, 32'd112,      32'd0};
    vecs[4]  = '{C_ADD, 2'd0, 2'd0, 2'd1, 2'd0, 32'd5,        32'd3,        32'd0, 32'd12,       1'b0, 32'd128,      32'd0};
    vecs[5]  = '{C_ADD, 2'd0, 2'd0, 2'd2, 2'd0, 32'd5,        32'd3,        32'd0, 32'd14,       1'b0, 32'd136,      32'd0};
    vecs[6]  = '{C_SRA, 2'd0, 2'd0, 2'd0, 2'd0, 32'h8000_0000, 32'd4,       32'd0, 32'hF800_0000, 1'b0, 32'd116,     32'd0};
    vecs[7]  = '{C_SRL, 2'd0, 2'd0, 2'd0, 2'd0, 32'h8000_0000, 32'd4,       32'd0, 32'h0800_0000, 1'b0, 32'd116,     32'd0};
    vecs[8]  = '{C_SUB, 2'd0, 2'd0, 2'd0, 2'd0, 32'd1,        32'd2,        32'd0, 32'hFFFF_FFFF, 1'b0, 32'd108,     32'd0};
    vecs[9]  = '{C_AND, 2'd0, 2'd0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0, 32'h0000_F000, 1'b0, 32'h3FC64,   32'd0};
    vecs[10] = '{C_OR,  2'd0, 2'd0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0, 32'h0000_FFF0, 1'b0, 32'h3FC64,   32'd0};
    vecs[11] = '{C_NOR, 2'd0, 2'd0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0, 32'hFFFF_000F, 1'b0, 32'h3FC64,   32'd0};
    vecs[12] = '{C_XOR, 2'd0, 2'd0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0, 32'h0000_0FF0, 1'b0, 32'h3FC64,   32'd0};
    vecs[13] = '{C_SLL, 2'd0, 2'd0, 2'd0, 2'd0, 32'd1,        32'd31,       32'd0, 32'h8000_0000, 1'b0, 32'd224,     32'd0};
    vecs[14] = '{C_SLA, 2'd0, 2'd0, 2'd0, 2'd0, 32'd1,        32'd35,       32'd0, 32'd8,        1'b0, 32'd240,      32'd0};
    vecs[15] = '{4'h3,  2'd0, 2'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd0,        1'b0, 32'd112,      32'd0};
    vecs[16] = '{4'hF,  2'd0, 2'd0, 2'd0, 2'd0, 32'd5,        32'd3,        32'd0, 32'd0,        1'b0, 32'd112,      32'd0};
    vecs[17] = '{C_ADD, 2'd1, 2'd0, 2'd0, 2'd0, 32'd0,        32'd3,        32'd0, 32'd3,        1'b1, 32'd112,      32'd0};
    vecs[18] = '{C_ADD, 2'd1, 2'd0, 2'd0, 2'd0, 32'd1,        32'd3,        32'd0, 32'd4,        1'b0, 32'd112,      32'd0};
    vecs[19] = '{C_ADD, 2'd2, 2'd0, 2'd0, 2'd0, 32'd4,        32'd3,        32'd4, 32'd7,        1'b0, 32'd112,      32'd4};
    vecs[20] = '{C_ADD, 2'd2, 2'd0, 2'd0, 2'd0, 32'd4,        32'd3,        32'd5, 32'd7,        1'b1, 32'd112,      32'd5};
    vecs[21] = '{C_ADD, 2'd2, 2'd0, 2'd0, 2'd2, 32'd4,        32'd3,        32'd4, 32'd7,        1'b1, 32'd112,      32'd9};
    vecs[22] = '{C_ADD, 2'd2, 2'd0, 2'd0, 2'd1, 32'd7,        32'd3,        32'd0, 32'd10,       1'b0, 32'd112,      32'd7};
    vecs[23] = '{C_ADD, 2'd3, 2'd0, 2'd0, 2'd0, 32'd0,        32'd3,        32'd0, 32'd3,        1'b1, 32'd112,      32'd0};
    vecs[24] = '{C_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 32'd0,        32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd96,    32'd0};
    vecs[25] = '{C_ADD, 2'd1, 2'd1, 2'd0, 2'd0, 32'd0,        32'd3,        32'd0, 32'd10,       1'b0, 32'd112,      32'd0};

    reset = 1'b0; pc_in = 32'd0; exe_cmd = 4'd0; branch_type = 2'd0;
    alu_inp1 = 32'd0; alu_inp2 = 32'd0; reg2 = 32'd0;
    fwd_sel1 = 2'd0; fwd_sel2 = 2'd0; fwd_sel_st = 2'd0;
    mem_fwd = 32'd0; wb_fwd = 32'd0;

    #12;
    check("rst_alu_result", alu_result, 32'd0);
    check("rst_st_val", st_val, 32'd0);
    check("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    check("rst_branch_addr", branch_addr, 32'd0);
    check("rst_freez_req", {31'd0, freez_req}, 32'd0);

    @(posedge clock); #1;
    reset = 1'b1; pc_in = 32'd100; mem_fwd = 32'd7; wb_fwd = 32'd9;

    for (int i = 0; i < NV; i++) begin
      @(posedge clock); #1;
      exe_cmd = vecs[i].cmd; branch_type = vecs[i].bt;
      fwd_sel1 = vecs[i].s1; fwd_sel2 = vecs[i].s2; fwd_sel_st = vecs[i].sst;
      alu_inp1 = vecs[i].i1; alu_inp2 = vecs[i].i2; reg2 = vecs[i].r2;
      @(negedge clock);
      check($sformatf("v%0d_res", i), alu_result, vecs[i].res);
      check($sformatf("v%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].tk});
      check($sformatf("v%0d_addr", i), branch_addr, vecs[i].addr);
      check($sformatf("v%0d_st", i), st_val, vecs[i].st);
    end

    @(posedge clock); #1;
    reg2 = 32'd0;
    run_md(C_MUL, 32'd12345, 32'd6789, 32'd83810205, "mul_big");
    exe_cmd = C_ADD; alu_inp1 = 32'd5; alu_inp2 = 32'd3;
    @(negedge clock);
    check("post_mul_idle_freez", {31'd0, freez_req}, 32'd0);
    check("post_mul_idle_res", alu_result, 32'd8);

    @(posedge clock); #1;
    run_md(C_DIV, 32'd100, 32'd7, 32'd14, "div_100_7");
    run_md(C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_0");
    run_md(C_DIV, 32'd100, 32'd7, 32'd14, "b2b_div");
    run_md(C_MUL, 32'd2, 32'd3, 32'd6, "b2b_mul");

    // Abort a MUL while its counter reads 10 (twelfth frozen cycle).
    exe_cmd = C_MUL; alu_inp1 = 32'd12345; alu_inp2 = 32'd6789; branch_type = 2'd3;
    repeat (11) @(posedge clock);
    #2;
    check("mid_mul_freez", {31'd0, freez_req}, 32'd1);
    check("mid_mul_branch_gated", {31'd0, branch_taken}, 32'd0);
    reset = 1'b0;
    #1;
    check("async_rst_freez", {31'd0, freez_req}, 32'd0);
    check("async_rst_res", alu_result, 32'd0);
    exe_cmd = C_ADD; branch_type = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run_md(C_MUL, 32'd3, 32'd4, 32'd12, "mul_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
